display_sequencer: RTL and testbench
====================================

Name: display_sequencer

Overview:
Controller that owns the number/select/mode inputs of the 4-digit seven-segment display driver and sequences what the reaction game shows. It arbitrates between the mode banner, the live timer, a timed result readout, a per-mode best-score readout and a blinking early-press fault indication. It also keeps one best (minimum) reaction time per difficulty mode. It sits between the game FSM and the display driver, in the clk_500Hz domain.

Parameters:
HOLD_TICKS, 1000, cycles the RESULT and BEST screens are each held (2 s at 500 Hz)
FAULT_TICKS, 1000, cycles the FAULT screen is held
BLINK_HALF, 125, half-period of the FAULT blink, in cycles
NO_SCORE, 13'd8191, sentinel for "no best yet"; also the reset value of each best register

Ports:
clk_500Hz  in  1  system/multiplex clock
rst  in  1  asynchronous, active-high reset
mode_sel  in  2  difficulty switches: 00 easy, 01 regular, 10 hard, 11 invalid
game_active  in  1  level, high while a round is running
live_time  in  13  running reaction timer, in ms
result_valid  in  1  one-cycle pulse: a round ended with a valid reaction
result_time  in  13  reaction time in ms, sampled when result_valid=1
early_fault  in  1  one-cycle pulse: the player pressed too early
clear_best  in  1  one-cycle pulse: reset all best registers
number  out  13  to display driver
select  out  1  to display driver: 0 = mode banner, 1 = number
mode  out  2  to display driver: latched mode
busy  out  1  high in RESULT, BEST or FAULT
new_best  out  1  high throughout a RESULT screen whose value set a new best
best_time  out  13  best score of the current mode_q

Behaviour:
- All outputs are registered. Each output reflects its inputs one clock after they are sampled.
- Reset values: state MENU, mode_q=00, all three best registers = NO_SCORE, timer=0, blink=0, number=0, select=0, mode=00, busy=0, new_best=0.
- Mode latch: mode_q <= mode_sel only in state MENU with game_active=0 and mode_sel!=11. mode_sel=11 keeps the previous mode_q. The mode output always equals mode_q.
- States and outputs:
  MENU: select=0, number=0.
  LIVE: select=1, number=live_time.
  RESULT: select=1, number=the captured result.
  BEST: select=1, number=best[mode_q].
  FAULT: blink=0 gives select=1, number=0; blink=1 gives select=0 (banner).
- Event priority in every state: early_fault > result_valid > game_active/timer expiry.
- MENU: early_fault -> FAULT; result_valid -> RESULT; game_active=1 -> LIVE.
- LIVE: early_fault -> FAULT; result_valid -> RESULT; game_active=0 -> MENU.
- RESULT: timer reaches HOLD_TICKS-1 -> BEST. A new result_valid restarts RESULT with the new value and reloads the timer. early_fault -> FAULT.
- BEST: timer reaches HOLD_TICKS-1 -> MENU. result_valid -> RESULT. early_fault -> FAULT.
- FAULT:
  - The blink toggles every BLINK_HALF cycles, starting at 0 on entry.
  - Timer reaches FAULT_TICKS-1 -> MENU.
  - A repeat early_fault restarts the timer and clears blink.
  - result_valid is ignored.
- Timer: cleared on every state entry, incremented otherwise. It is 10 bits wide and sized for the largest of the three count parameters.
- Capture on result_valid:
  - result register <= result_time.
  - If result_time < best[mode_q], best[mode_q] <= result_time and new_best <= 1; otherwise new_best <= 0.
  - A tie does not count as a new best.
  - new_best clears on leaving RESULT.
- clear_best: all best registers <= NO_SCORE in the same cycle. If the block is in BEST, it goes to MENU next cycle. If clear_best coincides with result_valid, the clear applies first, so best[mode_q] <= result_time and new_best=1.
- Values above 9999 cannot occur, since 13 bits saturate at 8191. No clamping is required.
- rst asserted mid-screen returns everything to reset values immediately, including the best registers.

Decomposition:
- Shared package display_pkg holds:
  - state encoding (MENU, LIVE, RESULT, BEST, FAULT)
  - mode constants MODE_EASY=00, MODE_REG=01, MODE_HARD=10, MODE_BAD=11
  - NO_SCORE
- One natural sub-module: hold_timer, an up-counter with synchronous clear, terminal-count compare input and blink toggle output. It is reused for the HOLD and FAULT durations.

Test Plan:
1. Reset, then mode_sel=10 with game_active=0 -> after 1 cycle mode=10, select=0. Then mode_sel=11 -> mode stays 10.
2. game_active=1, live_time=1234 -> select=1, number=1234. game_active=0 -> MENU, select=0.
3. result_valid with result_time=350 in mode 00 -> RESULT: number=350, new_best=1, busy=1. After 1000 cycles -> BEST: number=350. After 1000 more cycles -> MENU, busy=0.
4. A second result of 400, then one of 350, in mode 00 -> new_best=0 for both, and best stays 350. A result of 300 in mode 01 -> new_best=1 with best_time=300, while mode 00's best stays 350.
5. early_fault in LIVE -> FAULT: number=0 with select=1 for 125 cycles, then select=0 for 125 cycles, repeating. result_valid in FAULT is ignored. MENU after 1000 cycles.
6. clear_best while in BEST -> MENU the next cycle, best_time=8191. rst asserted mid-RESULT -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared types and constants for the reaction-game display
//               sequencer: screen state encoding, difficulty mode codes,
//               the "no best score yet" sentinel and a small sizing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    typedef enum logic [2:0] {
        MENU   = 3'd0,
        LIVE   = 3'd1,
        RESULT = 3'd2,
        BEST   = 3'd3,
        FAULT  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_EASY = 2'b00;
    localparam logic [1:0] MODE_REG  = 2'b01;
    localparam logic [1:0] MODE_HARD = 2'b10;
    localparam logic [1:0] MODE_BAD  = 2'b11;

    // Largest representable 13-bit value doubles as "no score recorded".
    localparam logic [12:0] NO_SCORE = 13'd8191;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : hold_timer
// Description : Screen-duration up-counter with synchronous clear, terminal
//               count compare and a blink phase that toggles every
//               BLINK_HALF cycles, restarting low on every clear.
// Ports       : clk      - clock
//               rst      - asynchronous active-high reset
//               clear    - restart count and blink phase this cycle
//               terminal - count value that raises done
//               done     - current count equals terminal
//               blink_d  - blink value that will be held after this edge
// Revision    : 1.0 - initial release
// ============================================================================
module hold_timer #(
    parameter int TIMER_W    = 10,
    parameter int BLINK_HALF = 125
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [TIMER_W-1:0] terminal,
    output logic               done,
    output logic               blink_d
);

    localparam int             BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_HALF - 1);

    logic [TIMER_W-1:0] count_q, count_d;
    logic [BW-1:0]      phase_q, phase_d;
    logic               blink_q;

    always_comb begin
        count_d = count_q + 1'b1;
        phase_d = phase_q + 1'b1;
        blink_d = blink_q;
        if (clear) begin
            count_d = '0;
            phase_d = '0;
            blink_d = 1'b0;
        end else if (phase_q == BLINK_LAST) begin
            phase_d = '0;
            blink_d = ~blink_q;
        end
    end

    assign done = (count_q == terminal);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            phase_q <= '0;
            blink_q <= 1'b0;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
            blink_q <= blink_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/display_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : display_sequencer
// Description : Owns the number/select/mode inputs of the 4-digit display
//               driver. Arbitrates mode banner, live timer, timed result
//               readout, per-mode best score and a blinking early-press
//               fault screen; keeps one minimum reaction time per mode.
// Ports       : clk_500Hz    - clock
//               rst          - asynchronous active-high reset
//               mode_sel     - difficulty switches (11 is ignored)
//               game_active  - high while a round runs
//               live_time    - running reaction timer (ms)
//               result_valid - pulse: valid reaction, result_time sampled
//               result_time  - reaction time (ms)
//               early_fault  - pulse: player pressed too early
//               clear_best   - pulse: forget all best scores
//               number       - value to display
//               select       - 0 = mode banner, 1 = number
//               mode         - latched difficulty mode
//               busy         - a timed screen (RESULT/BEST/FAULT) is up
//               new_best     - the shown result set a new best
//               best_time    - best score of the current mode
// Revision    : 1.0 - initial release
// ============================================================================
module display_sequencer
    import display_pkg::*;
#(
    parameter int HOLD_TICKS  = 1000,
    parameter int FAULT_TICKS = 1000,
    parameter int BLINK_HALF  = 125
) (
    input  logic        clk_500Hz,
    input  logic        rst,
    input  logic [1:0]  mode_sel,
    input  logic        game_active,
    input  logic [12:0] live_time,
    input  logic        result_valid,
    input  logic [12:0] result_time,
    input  logic        early_fault,
    input  logic        clear_best,
    output logic [12:0] number,
    output logic        select,
    output logic [1:0]  mode,
    output logic        busy,
    output logic        new_best,
    output logic [12:0] best_time
);

    localparam int                 TIMER_W    = $clog2(max3(HOLD_TICKS, FAULT_TICKS, BLINK_HALF));
    localparam logic [TIMER_W-1:0] HOLD_LAST  = TIMER_W'(HOLD_TICKS - 1);
    localparam logic [TIMER_W-1:0] FAULT_LAST = TIMER_W'(FAULT_TICKS - 1);

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [12:0]        result_q, result_d;
    logic [12:0]        best_q [3];
    logic [12:0]        best_d [3];
    logic [12:0]        number_q, number_d;
    logic               select_q, select_d;
    logic               busy_q, busy_d;
    logic               new_best_q, new_best_d;
    logic [12:0]        best_time_q, best_time_d;

    logic               accept;
    logic               restart;
    logic               timer_clear;
    logic               timer_done;
    logic               blink_d;
    logic               beats_best;
    logic [12:0]        best_cur;
    logic [12:0]        best_view;
    logic [TIMER_W-1:0] terminal;

    assign terminal    = (state_q == FAULT) ? FAULT_LAST : HOLD_LAST;
    // Any state change, or a same-state restart, begins a fresh screen.
    assign timer_clear = (state_d != state_q) || restart;

    hold_timer #(
        .TIMER_W    (TIMER_W),
        .BLINK_HALF (BLINK_HALF)
    ) u_hold_timer (
        .clk      (clk_500Hz),
        .rst      (rst),
        .clear    (timer_clear),
        .terminal (terminal),
        .done     (timer_done),
        .blink_d  (blink_d)
    );

    // Next screen: early_fault beats result_valid beats everything else.
    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        accept  = 1'b0;
        if (early_fault) begin
            state_d = FAULT;
            restart = 1'b1;
        end else if (result_valid && (state_q != FAULT)) begin
            state_d = RESULT;
            restart = 1'b1;
            accept  = 1'b1;
        end else if (clear_best && (state_q == BEST)) begin
            state_d = MENU;
        end else begin
            case (state_q)
                MENU:    if (game_active)  state_d = LIVE;
                LIVE:    if (!game_active) state_d = MENU;
                RESULT:  if (timer_done)   state_d = BEST;
                BEST:    if (timer_done)   state_d = MENU;
                FAULT:   if (timer_done)   state_d = MENU;
                default: state_d = MENU;
            endcase
        end
    end

    // Mode latch, best-score bookkeeping and registered output values.
    always_comb begin
        mode_d = mode_q;
        if ((state_q == MENU) && !game_active && (mode_sel != MODE_BAD)) begin
            mode_d = mode_sel;
        end

        // The clear is applied before the comparison so a result arriving
        // together with clear_best always becomes the new best.
        best_cur = NO_SCORE;
        for (int i = 0; i < 3; i++) begin
            best_d[i] = clear_best ? NO_SCORE : best_q[i];
            if (2'(i) == mode_q) begin
                best_cur = best_d[i];
            end
        end
        beats_best = (result_time < best_cur);

        result_d   = result_q;
        new_best_d = (state_d == RESULT) ? new_best_q : 1'b0;
        if (accept) begin
            result_d   = result_time;
            new_best_d = beats_best;
            for (int i = 0; i < 3; i++) begin
                if (beats_best && (2'(i) == mode_q)) begin
                    best_d[i] = result_time;
                end
            end
        end

        best_view = NO_SCORE;
        for (int i = 0; i < 3; i++) begin
            if (2'(i) == mode_d) begin
                best_view = best_d[i];
            end
        end

        number_d    = '0;
        select_d    = 1'b0;
        busy_d      = 1'b0;
        best_time_d = best_view;
        case (state_d)
            LIVE: begin
                number_d = live_time;
                select_d = 1'b1;
            end
            RESULT: begin
                number_d = result_d;
                select_d = 1'b1;
                busy_d   = 1'b1;
            end
            BEST: begin
                number_d = best_view;
                select_d = 1'b1;
                busy_d   = 1'b1;
            end
            FAULT: begin
                // Blink low shows a blank zero, blink high shows the banner.
                select_d = ~blink_d;
                busy_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_500Hz or posedge rst) begin
        if (rst) begin
            state_q     <= MENU;
            mode_q      <= MODE_EASY;
            result_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                best_q[i] <= NO_SCORE;
            end
            number_q    <= '0;
            select_q    <= 1'b0;
            busy_q      <= 1'b0;
            new_best_q  <= 1'b0;
            best_time_q <= NO_SCORE;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            result_q    <= result_d;
            for (int i = 0; i < 3; i++) begin
                best_q[i] <= best_d[i];
            end
            number_q    <= number_d;
            select_q    <= select_d;
            busy_q      <= busy_d;
            new_best_q  <= new_best_d;
            best_time_q <= best_time_d;
        end
    end

    assign number    = number_q;
    assign select    = select_q;
    assign mode      = mode_q;
    assign busy      = busy_q;
    assign new_best  = new_best_q;
    assign best_time = best_time_q;

endmodule
`default_nettype wire

// File: tb/tb_display_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_sequencer
// Description : Self-checking bench for display_sequencer. A screen-level
//               reference model (screen name, cycles since entry, blink from
//               elapsed time) predicts every output each cycle; directed
//               stimulus adds hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_sequencer;

    localparam int HOLD  = 1000;
    localparam int FLT   = 1000;
    localparam int BH    = 125;
    localparam int NOSC  = 8191;

    localparam int S_MENU   = 0;
    localparam int S_LIVE   = 1;
    localparam int S_RESULT = 2;
    localparam int S_BEST   = 3;
    localparam int S_FAULT  = 4;

    logic        clk_500Hz = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode_sel = 2'b00;
    logic        game_active = 1'b0;
    logic [12:0] live_time = '0;
    logic        result_valid = 1'b0;
    logic [12:0] result_time = '0;
    logic        early_fault = 1'b0;
    logic        clear_best = 1'b0;
    logic [12:0] number;
    logic        select;
    logic [1:0]  mode;
    logic        busy;
    logic        new_best;
    logic [12:0] best_time;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_500Hz = ~clk_500Hz;

    display_sequencer dut (
        .clk_500Hz    (clk_500Hz),
        .rst          (rst),
        .mode_sel     (mode_sel),
        .game_active  (game_active),
        .live_time    (live_time),
        .result_valid (result_valid),
        .result_time  (result_time),
        .early_fault  (early_fault),
        .clear_best   (clear_best),
        .number       (number),
        .select       (select),
        .mode         (mode),
        .busy         (busy),
        .new_best     (new_best),
        .best_time    (best_time)
    );

    // ---------------- reference model ----------------
    int          m_scr;
    int          m_el;
    int          m_res;
    int          m_best [4];
    logic [1:0]  m_mode;
    logic        m_nb;
    int          nxt;
    bit          rest;
    logic [12:0] e_number;
    logic        e_select;
    logic        e_busy;
    logic [12:0] e_best;

    always @(posedge clk_500Hz or posedge rst) begin
        if (rst) begin
            m_scr = S_MENU;
            m_el  = 0;
            m_res = 0;
            for (int i = 0; i < 4; i++) m_best[i] = NOSC;
            m_mode   = 2'b00;
            m_nb     = 1'b0;
            e_number = '0;
            e_select = 1'b0;
            e_busy   = 1'b0;
            e_best   = 13'(NOSC);
        end else begin
            nxt  = m_scr;
            rest = 1'b0;
            if (clear_best) for (int i = 0; i < 4; i++) m_best[i] = NOSC;
            if (early_fault) begin
                nxt  = S_FAULT;
                rest = 1'b1;
            end else if (result_valid && m_scr != S_FAULT) begin
                nxt   = S_RESULT;
                rest  = 1'b1;
                m_res = int'(result_time);
                m_nb  = (int'(result_time) < m_best[m_mode]);
                if (m_nb) m_best[m_mode] = int'(result_time);
            end else if (clear_best && m_scr == S_BEST) begin
                nxt = S_MENU;
            end else if (m_scr == S_MENU && game_active) begin
                nxt = S_LIVE;
            end else if (m_scr == S_LIVE && !game_active) begin
                nxt = S_MENU;
            end else if (m_scr == S_RESULT && m_el == HOLD - 1) begin
                nxt = S_BEST;
            end else if (m_scr == S_BEST && m_el == HOLD - 1) begin
                nxt = S_MENU;
            end else if (m_scr == S_FAULT && m_el == FLT - 1) begin
                nxt = S_MENU;
            end
            if (m_scr == S_MENU && !game_active && mode_sel != 2'b11) m_mode = mode_sel;
            if (nxt != m_scr || rest) m_el = 0;
            else                      m_el = m_el + 1;
            if (nxt != S_RESULT) m_nb = 1'b0;
            m_scr = nxt;

            e_best   = 13'(m_best[m_mode]);
            e_number = '0;
            e_select = 1'b0;
            e_busy   = 1'b0;
            case (m_scr)
                S_LIVE:   begin e_number = live_time; e_select = 1'b1; end
                S_RESULT: begin e_number = 13'(m_res); e_select = 1'b1; e_busy = 1'b1; end
                S_BEST:   begin e_number = e_best; e_select = 1'b1; e_busy = 1'b1; end
                S_FAULT:  begin e_select = (((m_el / BH) % 2) == 0); e_busy = 1'b1; end
                default:  ;
            endcase
        end
    end

    // ---------------- checking helpers ----------------
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_500Hz);
            n_checks++;
            if ({number, select, mode, busy, new_best, best_time} !==
                {e_number, e_select, m_mode, e_busy, m_nb, e_best}) begin
                $display("FAIL model_cycle t=%0t got num=%0d sel=%0b mode=%0d busy=%0b nb=%0b best=%0d want num=%0d sel=%0b mode=%0d busy=%0b nb=%0b best=%0d",
                         $time, number, select, mode, busy, new_best, best_time,
                         e_number, e_select, m_mode, e_busy, m_nb, e_best);
            end else begin
                n_pass++;
            end
        end
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s got %0d want %0d", nm, act, exp);
        else             n_pass++;
    endtask

    task automatic pulse_result(input int t);
        result_valid = 1'b1;
        result_time  = 13'(t);
        step(1);
        result_valid = 1'b0;
    endtask

    task automatic pulse_fault();
        early_fault = 1'b1;
        step(1);
        early_fault = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int cnt;
        cnt = 0;
        while (busy && cnt < budget) begin
            step(1);
            cnt++;
        end
        check("wait_idle_busy", int'(busy), 0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        step(2);
        rst = 1'b0;
        step(1);
        check("rst_number", int'(number), 0);
        check("rst_select", int'(select), 0);
        check("rst_mode", int'(mode), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_new_best", int'(new_best), 0);
        check("rst_best_time", int'(best_time), NOSC);

        // mode latch, invalid code held off
        mode_sel = 2'b10;
        step(1);
        check("mode_latch_hard", int'(mode), 2);
        check("mode_banner_sel", int'(select), 0);
        mode_sel = 2'b11;
        step(2);
        check("mode_bad_ignored", int'(mode), 2);

        // live timer passthrough
        game_active = 1'b1;
        live_time   = 13'd1234;
        step(1);
        check("live_sel", int'(select), 1);
        check("live_num", int'(number), 1234);
        live_time = 13'd42;
        step(1);
        check("live_num2", int'(number), 42);
        game_active = 1'b0;
        step(1);
        check("live_exit_sel", int'(select), 0);
        mode_sel = 2'b00;
        step(1);
        check("mode_easy", int'(mode), 0);

        // first result, hold timing
        pulse_result(350);
        check("res_num", int'(number), 350);
        check("res_new_best", int'(new_best), 1);
        check("res_busy", int'(busy), 1);
        check("res_best_time", int'(best_time), 350);
        step(999);
        check("res_last_num", int'(number), 350);
        check("res_last_nb", int'(new_best), 1);
        step(1);
        check("best_num", int'(number), 350);
        check("best_nb_clr", int'(new_best), 0);
        check("best_busy", int'(busy), 1);
        step(999);
        check("best_last_busy", int'(busy), 1);
        step(1);
        check("best_exit_busy", int'(busy), 0);
        check("best_exit_sel", int'(select), 0);

        // worse result, tie, then another mode
        pulse_result(400);
        check("worse_nb", int'(new_best), 0);
        check("worse_num", int'(number), 400);
        pulse_result(350);
        check("tie_nb", int'(new_best), 0);
        check("tie_best_time", int'(best_time), 350);
        check("model_best0", m_best[0], 350);
        wait_idle(2100);
        mode_sel = 2'b01;
        step(1);
        check("mode_reg", int'(mode), 1);
        check("mode_reg_best", int'(best_time), NOSC);
        pulse_result(300);
        check("reg_nb", int'(new_best), 1);
        check("reg_best", int'(best_time), 300);
        wait_idle(2100);
        mode_sel = 2'b00;
        step(1);
        check("easy_best_kept", int'(best_time), 350);
        check("model_best1", m_best[1], 300);

        // fault blink from LIVE
        game_active = 1'b1;
        step(1);
        pulse_fault();
        check("flt_num", int'(number), 0);
        check("flt_sel0", int'(select), 1);
        check("flt_busy", int'(busy), 1);
        step(124);
        check("flt_sel_124", int'(select), 1);
        step(1);
        check("flt_sel_125", int'(select), 0);
        step(125);
        check("flt_sel_250", int'(select), 1);
        pulse_result(100);
        check("flt_ignore_num", int'(number), 0);
        check("flt_ignore_nb", int'(new_best), 0);
        check("flt_ignore_best", int'(best_time), 350);
        game_active = 1'b0;
        step(748);
        check("flt_last_busy", int'(busy), 1);
        check("flt_last_sel", int'(select), 0);
        step(1);
        check("flt_exit_busy", int'(busy), 0);

        // repeat fault restarts timer and blink
        pulse_fault();
        step(199);
        check("flt2_sel_200", int'(select), 0);
        pulse_fault();
        check("flt2_restart_sel", int'(select), 1);
        step(124);
        check("flt2_sel_124", int'(select), 1);
        step(1);
        check("flt2_sel_125", int'(select), 0);
        wait_idle(1100);

        // clear_best in BEST, clear coinciding with result
        pulse_result(500);
        check("res500_nb", int'(new_best), 0);
        step(1000);
        check("best2_num", int'(number), 350);
        clear_best = 1'b1;
        step(1);
        clear_best = 1'b0;
        check("clr_busy", int'(busy), 0);
        check("clr_sel", int'(select), 0);
        check("clr_best_time", int'(best_time), NOSC);
        mode_sel = 2'b10;
        step(1);
        check("mode_hard2", int'(mode), 2);
        clear_best   = 1'b1;
        result_valid = 1'b1;
        result_time  = 13'd600;
        step(1);
        clear_best   = 1'b0;
        result_valid = 1'b0;
        check("clr_res_nb", int'(new_best), 1);
        check("clr_res_best", int'(best_time), 600);
        step(5);

        // asynchronous reset mid-RESULT
        #2;
        rst = 1'b1;
        #1;
        check("arst_number", int'(number), 0);
        check("arst_select", int'(select), 0);
        check("arst_mode", int'(mode), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_new_best", int'(new_best), 0);
        check("arst_best_time", int'(best_time), NOSC);
        step(2);
        mode_sel = 2'b00;
        rst = 1'b0;
        step(2);
        check("post_rst_best", int'(best_time), NOSC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
